// File: rtl/bus_pkg.sv
// Shared types and legality limits for the multi-master tri-state bus.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } bus_state_e;

    localparam int M_MIN        = 2;
    localparam int M_MAX        = 16;
    localparam int MAX_HOLD_MIN = 1;

    // Index/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/multi_master_tristate_bus_if.sv
// Master-side request/data lines and arbiter-side grant/readback lines.
interface multi_master_tristate_bus_if
    import bus_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
);
    localparam int OW = clog2_min1(M);

    logic [M-1:0]   req;
    logic [M*N-1:0] data_in;
    logic [M-1:0]   grant;
    logic [N-1:0]   bus_data;
    logic           bus_valid;
    logic [OW-1:0]  owner;

    modport master (output req, output data_in,
                    input grant, input bus_data, input bus_valid, input owner);
    modport slave  (input req, input data_in,
                    output grant, output bus_data, output bus_valid, output owner);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr_i, wrapping.
module rr_arbiter #(
    parameter int M  = 4,
    parameter int IW = 2
) (
    input  logic [M-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [M-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o
);
    logic found;
    int   j;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < M; k++) begin
            j = int'(rr_ptr_i) + k;
            if (j >= M) j = j - M;
            if (!found && req_i[j]) begin
                found        = 1'b1;
                win_oh_o[j]  = 1'b1;
                win_idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/tristate_buf.sv
// Single tri-state driver cell: drives y_o with a_i when enabled, else floats.
module tristate_buf #(
    parameter int W = 8
) (
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    output tri   [W-1:0] y_o
);
    assign y_o = en_i ? a_i : {W{1'bz}};
endmodule

// File: rtl/multi_master_tristate_bus.sv
// Round-robin arbiter with hold limit and a one-cycle turnaround gap,
// steering M masters onto one shared tri-state bus.
module multi_master_tristate_bus
    import bus_pkg::*;
#(
    parameter int N        = 8,
    parameter int M        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    multi_master_tristate_bus_if.slave bus
);
    localparam int IW = clog2_min1(M);
    localparam int HW = clog2_min1(MAX_HOLD);

    if (M < M_MIN || M > M_MAX) begin : g_bad_m
        $error("multi_master_tristate_bus: M out of range");
    end
    if (MAX_HOLD < MAX_HOLD_MIN) begin : g_bad_hold
        $error("multi_master_tristate_bus: MAX_HOLD must be >= 1");
    end

    bus_state_e    state_q, state_d;
    logic [M-1:0]  grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [IW-1:0] rr_q,    rr_d;

    logic [M-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          do_arb;
    logic          hold_at_max;
    logic          others_req;

    rr_arbiter #(.M(M), .IW(IW)) u_arb (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    assign hold_at_max = (hold_q == HW'(MAX_HOLD - 1));
    assign others_req  = |(bus.req & ~grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        do_arb  = 1'b0;
        unique case (state_q)
            IDLE, TURN: do_arb = 1'b1;
            OWN: begin
                // Owner quit, or its slot expired with someone waiting: insert dead cycle.
                if (!bus.req[owner_q] || (hold_at_max && others_req)) begin
                    state_d = TURN;
                    grant_d = '0;
                    owner_d = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else if (hold_at_max) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_arb) begin
            if (|bus.req) begin
                state_d = OWN;
                grant_d = win_oh;
                owner_d = win_idx;
                valid_d = 1'b1;
                hold_d  = '0;
                rr_d    = (win_idx == IW'(M - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
        end
    end

    tri [N-1:0] bus_w;

    for (genvar i = 0; i < M; i++) begin : g_drv
        tristate_buf #(.W(N)) u_buf (
            .en_i (grant_q[i]),
            .a_i  (bus.data_in[i*N +: N]),
            .y_o  (bus_w)
        );
    end

    // Masking keeps the floating bus from ever leaking Z to readers.
    assign bus.bus_data  = valid_q ? bus_w : '0;
    assign bus.grant     = grant_q;
    assign bus.bus_valid = valid_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_multi_master_tristate_bus.sv
// Directed checks of arbitration order, hold limit, turnaround and reset.
module tb_multi_master_tristate_bus;
    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   inv_err = 0;
    bit   mon_en = 1'b0;
    logic [7:0] dat [4];
    logic [3:0] eg;

    always #5 clk = ~clk;

    multi_master_tristate_bus_if #(.N(N), .M(M)) bif ();

    multi_master_tristate_bus #(.N(N), .M(M), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < M; i++) bif.data_in[i*N +: N] = dat[i];
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Invariants on every cycle once outputs are defined.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!$onehot0(bif.grant)) inv_err++;
            if ($isunknown(bif.bus_data)) inv_err++;
            if (!bif.bus_valid && bif.bus_data != '0) inv_err++;
            if (!bif.bus_valid && bif.owner != '0) inv_err++;
        end
    end

    initial begin
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        bif.req = '0;
        load_data();

        // Reset state
        rst = 1'b1;
        tick(); tick();
        mon_en = 1'b1;
        chk("rst_grant", bif.grant, 0);
        chk("rst_valid", bif.bus_valid, 0);
        chk("rst_owner", bif.owner, 0);
        chk("rst_data",  bif.bus_data, 0);

        // Single requester, latency 1
        rst = 1'b0;
        bif.req = 4'b0001;
        tick();
        chk("m0_grant", bif.grant, 4'b0001);
        chk("m0_owner", bif.owner, 0);
        chk("m0_valid", bif.bus_valid, 1);
        chk("m0_data",  bif.bus_data, 8'h11);
        bif.req = '0;
        tick();
        chk("m0_drop_grant", bif.grant, 0);
        tick();

        // All requesting: 4-cycle slots separated by a dead cycle
        rst_pulse();
        bif.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 5; c++) begin
                tick();
                eg = (c < 4) ? 4'(1 << g) : 4'b0000;
                chk("rr_grant", bif.grant, eg);
                if (c < 4) begin
                    chk("rr_owner", bif.owner, g);
                    chk("rr_data",  bif.bus_data, dat[g]);
                end
            end
        end
        tick();
        chk("rr_wrap_grant", bif.grant, 4'b0001);

        // Sole requester keeps bus without turnaround; data follows the master live
        rst_pulse();
        bif.req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) begin
                dat[2] = 8'hA5;
                load_data();
            end
            tick();
            chk("solo_grant", bif.grant, 4'b0100);
            if (c == 6) chk("solo_data_upd", bif.bus_data, 8'hA5);
        end

        // Master 1 owns two cycles, drops; master 3 takes over after one gap
        bif.req = '0;
        tick(); tick();
        bif.req = 4'b0010;
        tick();
        chk("drop_g1", bif.grant, 4'b0010);
        bif.req = 4'b1010;
        tick();
        chk("drop_g2", bif.grant, 4'b0010);
        bif.req = 4'b1000;
        tick();
        chk("drop_turn", bif.grant, 4'b0000);
        tick();
        chk("drop_g3", bif.grant, 4'b1000);
        chk("drop_data", bif.bus_data, 8'h44);

        // Reset mid-ownership clears pointer
        rst_pulse();
        bif.req = 4'b0100;
        tick(); tick();
        chk("mid_own", bif.grant, 4'b0100);
        rst = 1'b1;
        bif.req = 4'b1111;
        tick();
        chk("midrst_grant", bif.grant, 0);
        chk("midrst_data",  bif.bus_data, 0);
        chk("midrst_valid", bif.bus_valid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_grant", bif.grant, 4'b0001);
        chk("post_rst_owner", bif.owner, 0);

        tick();
        chk("invariants", inv_err, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
